// File: rtl/pulse_pkg.sv
// pulse_pkg: definitions shared by the pulse generator and the pulse receiver.
//   MS_PER_MIN      - milliseconds per minute; the accumulator wraps here
//   MAX_BPM_DEFAULT - default ceiling for a requested beat rate
//   bcd_t           - one BCD digit
//   synth_state_t   - beat generator states
package pulse_pkg;

  localparam int unsigned MS_PER_MIN      = 60000;
  localparam int unsigned MAX_BPM_DEFAULT = 250;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    ERR
  } synth_state_t;

endpackage

// File: rtl/pulse_synth_bcd3_to_bin.sv
// bcd3_to_bin: combinational conversion of three BCD digits to binary.
//   d2_i, d1_i, d0_i - hundreds, tens and ones digits
//   bin_o            - d2*100 + d1*10 + d0 (0..999 for valid digits)
//   invalid_o        - high when any digit is above 9; bin_o is then meaningless
module bcd3_to_bin
  import pulse_pkg::*;
(
  input  bcd_t       d2_i,
  input  bcd_t       d1_i,
  input  bcd_t       d0_i,
  output logic [9:0] bin_o,
  output logic       invalid_o
);

  assign bin_o     = 10'(d2_i) * 10'd100 + 10'(d1_i) * 10'd10 + 10'(d0_i);
  assign invalid_o = (d2_i > 4'd9) || (d1_i > 4'd9) || (d0_i > 4'd9);

endmodule

// File: rtl/pulse_synth.sv
// pulse_synth: synthetic heartbeat generator driven by a BCD beat rate.
//   clk        - system clock
//   rst        - asynchronous, active-low reset
//   en         - run enable (level)
//   bd2/bd1/bd0- BCD hundreds/tens/ones of the requested beats per minute
//   pulse_out  - beat output, high for PULSE_MS ms per beat
//   beat_count - beats emitted so far, wraps 255 -> 0
//   err        - high while any digit is not a valid BCD value
module pulse_synth
  import pulse_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PULSE_MS    = 100,
  parameter int MAX_BPM     = MAX_BPM_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  bcd_t       bd2,
  input  bcd_t       bd1,
  input  bcd_t       bd0,
  output logic       pulse_out,
  output logic [7:0] beat_count,
  output logic       err
);

  localparam int TC      = CLK_FREQ_HZ / 1000 - 1;
  localparam int PRESC_W = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam int WIDTH_W = $clog2(PULSE_MS + 1);

  logic [9:0]         bin;
  logic               invalid;
  logic [9:0]         bpm_d, bpm_q;
  logic               err_q;
  synth_state_t       state_d, state_q;
  logic [PRESC_W-1:0] presc_d, presc_q;
  logic [15:0]        acc_d, acc_q;
  logic [WIDTH_W-1:0] width_d, width_q;
  logic [7:0]         beat_d, beat_q;
  logic               tick;
  logic               fire;
  logic [16:0]        sum;
  logic [16:0]        diff;

  bcd3_to_bin u_conv (
    .d2_i      (bd2),
    .d1_i      (bd1),
    .d0_i      (bd0),
    .bin_o     (bin),
    .invalid_o (invalid)
  );

  // An invalid rate reads as zero so a bad digit can never produce beats.
  always_comb begin
    bpm_d = bin;
    if (invalid)                 bpm_d = '0;
    else if (bin > 10'(MAX_BPM)) bpm_d = 10'(MAX_BPM);
  end

  // Millisecond strobe; the prescaler only runs outside IDLE.
  assign tick = (state_q != IDLE) && (presc_q == PRESC_W'(TC));

  // Wrapping accumulator: one beat each time bpm has been added 60000/bpm times.
  assign sum  = {1'b0, acc_q} + {7'b0, bpm_q};
  assign diff = sum - 17'(MS_PER_MIN);
  assign fire = tick && (sum >= 17'(MS_PER_MIN));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    acc_d   = acc_q;
    width_d = width_q;
    beat_d  = beat_q;

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // The rate keeps accumulating during HIGH so the period is independent of width.
    if (tick && (state_q == LOW || state_q == HIGH)) begin
      acc_d = fire ? diff[15:0] : sum[15:0];
    end

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        acc_d   = '0;
        if (en) state_d = err_q ? ERR : LOW;
      end
      LOW: begin
        if (err_q) begin
          state_d = ERR;
          acc_d   = '0;
        end else if (fire) begin
          state_d = HIGH;
          beat_d  = beat_q + 8'd1;
          width_d = WIDTH_W'(PULSE_MS);
        end
      end
      HIGH: begin
        // A fire here is intentionally ignored: a beat cannot start mid-pulse.
        if (err_q) begin
          state_d = ERR;
          acc_d   = '0;
          width_d = '0;
        end else if (tick) begin
          if (width_q <= WIDTH_W'(1)) begin
            state_d = LOW;
            width_d = '0;
          end else begin
            width_d = width_q - WIDTH_W'(1);
          end
        end
      end
      ERR: begin
        acc_d = '0;
        if (!err_q) state_d = LOW;
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      acc_d   = '0;
      width_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bpm_q   <= '0;
      err_q   <= 1'b0;
      state_q <= IDLE;
      presc_q <= '0;
      acc_q   <= '0;
      width_q <= '0;
      beat_q  <= '0;
    end else begin
      bpm_q   <= bpm_d;
      err_q   <= invalid;
      state_q <= state_d;
      presc_q <= presc_d;
      acc_q   <= acc_d;
      width_q <= width_d;
      beat_q  <= beat_d;
    end
  end

  assign pulse_out  = (state_q == HIGH);
  assign beat_count = beat_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pulse_synth.sv
module tb_pulse_synth;
  import pulse_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  bcd_t       bd2, bd1, bd0;
  logic       pulse_out;
  logic [7:0] beat_count;
  logic       err;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  pulse_synth #(
    .CLK_FREQ_HZ (1000),
    .PULSE_MS    (100),
    .MAX_BPM     (250)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bd2        (bd2),
    .bd1        (bd1),
    .bd0        (bd0),
    .pulse_out  (pulse_out),
    .beat_count (beat_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the cycle of the next 0->1 edge of pulse_out, or -1 on timeout.
  task automatic wait_rise(input int budget, output int at_cyc);
    int  n;
    bit  seen_low;
    n = 0;
    seen_low = 1'b0;
    at_cyc = -1;
    while (pulse_out && n < budget) begin
      step(1);
      n++;
    end
    while (!pulse_out && n < budget) begin
      seen_low = 1'b1;
      step(1);
      n++;
    end
    if (pulse_out && seen_low) at_cyc = cyc;
  endtask

  // Called right after a rise; counts cycles pulse_out stays high.
  task automatic measure_high(output int w);
    w = 0;
    while (pulse_out && w < 1000) begin
      w++;
      step(1);
    end
  endtask

  task automatic set_bpm(input bcd_t h, input bcd_t t, input bcd_t o);
    bd2 = h;
    bd1 = t;
    bd0 = o;
  endtask

  initial begin
    int base, r1, r2, r3, w, highs;

    rst = 1'b0;
    en  = 1'b0;
    set_bpm(4'd0, 4'd6, 4'd0);
    step(3);
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_beats", int'(beat_count), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b1;
    step(3);

    // 60 BPM: first beat 1001 cycles after enable, then every 1000.
    en = 1'b1;
    base = cyc;
    wait_rise(2000, r1);
    check("bpm60_rise1", r1 - base, 1001);
    measure_high(w);
    check("bpm60_high", w, 100);
    wait_rise(2000, r2);
    check("bpm60_rise2", r2 - base, 2001);
    wait_rise(2000, r3);
    check("bpm60_rise3", r3 - base, 3001);
    step(base + 3200 - cyc);
    check("bpm60_beats", int'(beat_count), 3);

    // Drop enable 50 cycles into a pulse.
    wait_rise(2000, r1);
    step(50);
    en = 1'b0;
    check("drop_before", int'(pulse_out), 1);
    step(1);
    check("drop_pulse", int'(pulse_out), 0);
    check("drop_beats", int'(beat_count), 4);
    step(5);
    en = 1'b1;
    base = cyc;
    wait_rise(2000, r1);
    check("reen_rise", r1 - base, 1001);
    check("reen_beats", int'(beat_count), 5);

    // 75 BPM from a clean start: first at 801, then 800 apart.
    en = 1'b0;
    step(2);
    set_bpm(4'd0, 4'd7, 4'd5);
    en = 1'b1;
    base = cyc;
    wait_rise(2000, r1);
    check("bpm75_rise1", r1 - base, 801);
    wait_rise(2000, r2);
    check("bpm75_space", r2 - r1, 800);

    // 999 BPM clamps to 250: 240-cycle period, 100 high.
    en = 1'b0;
    step(2);
    set_bpm(4'd9, 4'd9, 4'd9);
    en = 1'b1;
    base = cyc;
    wait_rise(2000, r1);
    check("bpm999_rise1", r1 - base, 241);
    measure_high(w);
    check("bpm999_high", w, 100);
    wait_rise(2000, r2);
    check("bpm999_space", r2 - r1, 240);
    check("bpm999_low", (r2 - r1) - w, 140);
    en = 1'b0;

    // Zero rate, then an invalid digit, then recovery.
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    set_bpm(4'd0, 4'd0, 4'd0);
    step(2);
    en = 1'b1;
    highs = 0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (pulse_out) highs++;
    end
    check("bpm0_highs", highs, 0);
    check("bpm0_beats", int'(beat_count), 0);
    set_bpm(4'd0, 4'd0, 4'hA);
    step(2);
    check("bad_err", int'(err), 1);
    check("bad_pulse", int'(pulse_out), 0);
    set_bpm(4'd0, 4'd6, 4'd0);
    base = cyc;
    step(1);
    check("fix_err", int'(err), 0);
    wait_rise(2000, r1);
    check("fix_rise", r1 - base, 1002);

    // Asynchronous reset in the middle of a pulse.
    step(10);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pulse", int'(pulse_out), 0);
    check("arst_beats", int'(beat_count), 0);
    check("arst_err", int'(err), 0);
    step(1);
    rst = 1'b1;

    // 250 BPM until the beat counter wraps.
    set_bpm(4'd2, 4'd5, 4'd0);
    step(2);
    for (int i = 0; i < 255; i++) wait_rise(400, r1);
    check("wrap_255", int'(beat_count), 255);
    wait_rise(400, r1);
    check("wrap_0", int'(beat_count), 0);
    check("wrap_timeout", int'(r1 > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_synth.md
Name: pulse_synth

Overview:
- Synthetic heartbeat generator for the Health Monitor lab: the transmit end of the pulse interface that pulse_monitor receives.
- Takes a target rate as three BCD digits (the same digit format pulse_monitor reports) and emits a clean active-high beat pulse at that rate.
- Used as a bench and bring-up stimulus in place of the analog pulse sensor, and as a self-test source selectable in the top level.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency; the prescaler terminal count is CLK_FREQ_HZ/1000 - 1.
- PULSE_MS, 100, beat high time in ms; constraint PULSE_MS*MAX_BPM < 60000.
- MAX_BPM, 250, clamp ceiling for the requested rate.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable, level-sensitive.
- bd2  input  4  BCD hundreds digit of BPM.
- bd1  input  4  BCD tens digit of BPM.
- bd0  input  4  BCD ones digit of BPM.
- pulse_out  output  1  generated beat, active high.
- beat_count  output  8  number of beats emitted, wraps 255->0.
- err  output  1  set while any BCD digit is greater than 9.

Behaviour:
- Reset (rst=0, asynchronous):
  - pulse_out=0, beat_count=0, err=0.
  - Accumulator, prescaler, width counter and registered BPM all cleared.
  - State=IDLE.
  - Release is taken on the next clk edge.
- BPM conversion:
  - bpm = bd2*100 + bd1*10 + bd0, registered, so there is 1 cycle of latency from digit change.
  - Clamped to MAX_BPM.
  - err is registered in the same cycle; when err=1 the registered bpm is forced to 0.
- ms tick:
  - Prescaler counts 0..CLK_FREQ_HZ/1000-1 while state != IDLE.
  - tick is a one-cycle strobe at terminal count.
- Rate accumulator (16 bit), updated only on tick:
  - sum = acc + bpm.
  - If sum >= 60000: acc <= sum - 60000 and fire=1.
  - Otherwise acc <= sum.
  - No division is used. The average period is exactly 60000/bpm ms, with 1 ms jitter for non-divisors.
- States:
  - IDLE: pulse_out=0.
    - en=1 and err=0 -> LOW, with acc and prescaler starting from 0.
    - en=1 and err=1 -> ERR.
  - LOW: pulse_out=0.
    - fire -> HIGH; pulse_out rises on the cycle after the tick, beat_count++, width counter loaded with PULSE_MS.
  - HIGH: pulse_out=1.
    - Width counter decrements on each tick; reaching 0 -> LOW.
    - A fire in HIGH is dropped and not counted; this is unreachable within the parameter constraint.
  - ERR: pulse_out=0, accumulator held at 0.
    - err clears -> LOW.
  - From any state, en=0 -> IDLE on the next cycle:
    - pulse truncated immediately;
    - acc and prescaler cleared;
    - beat_count held.
- Boundaries:
  - bpm=0: no beats are ever emitted; pulse_out stays 0 and the block stays in LOW.
  - A digit change mid-period takes effect at the next tick and acc is not reset, so there is no restart glitch.
  - beat_count 255 -> 0 on the next beat.

Decomposition:
- Shared package pulse_pkg:
  - MS_PER_MIN = 60000;
  - typedef bcd_t (logic [3:0]);
  - enum synth_state_t {IDLE, LOW, HIGH, ERR};
  - MAX_BPM default constant.
  - pulse_monitor reuses bcd_t from this package.
- One sub-module, bcd3_to_bin:
  - combinational digits -> 10-bit binary plus invalid flag;
  - clamping and registering stay in pulse_synth.

Test Plan (bench sets CLK_FREQ_HZ=1000, i.e. 1 cycle per ms):
- 060 BPM, en=1 at cycle 0 -> rising edges at cycles 1001, 2001, 3001; each high for 100 cycles; beat_count=3 at cycle 3200.
- 075 BPM -> rising-edge spacing exactly 800 cycles; 999 BPM -> clamped to 250, spacing 240 cycles, high 100, low 140.
- 000 BPM for 5000 cycles -> pulse_out stays 0, beat_count=0; then bd0=0xA -> err=1 two cycles later, pulse_out=0; digits 060 -> err=0, beats resume.
- en deasserted 50 cycles into a high pulse -> pulse_out=0 on the next cycle; beat_count unchanged; re-enable gives the first edge 1001 cycles later.
- rst asserted mid-HIGH with no clock edge -> pulse_out, beat_count and err are 0 immediately; 256 beats at 250 BPM -> beat_count wraps to 0.
- Loopback: pulse_synth at 072 BPM -> pulse_monitor reports pd2/pd1/pd0 = 0/7/2 within its averaging window.
